// File: rtl/bht_sat_predictor.sv
// Branch history table of saturating counters with optional gshare hashing.
// Registered 1-cycle lookup; single read-modify-write training port.
module bht_sat_predictor #(
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 2,
  parameter int GHR_W  = 4,
  parameter int GSHARE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_en,
  input  logic [31:0]      req_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic [GHR_W-1:0] ghr
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_RST =
    CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;
  logic             pv_q;
  logic             pt_q;
  logic [IDX_W-1:0] pi_q;

  logic [IDX_W-1:0] hash;
  logic [IDX_W-1:0] lk_idx;
  logic [CNT_W-1:0] upd_cur;
  logic [CNT_W-1:0] upd_nxt;
  logic [CNT_W-1:0] lk_cnt;
  logic             unused_pc;

  assign unused_pc = ^{req_pc[31:IDX_W+2], req_pc[1:0]};

  assign hash   = (GSHARE != 0) ? IDX_W'(ghr_q) : '0;
  assign lk_idx = req_pc[IDX_W+1:2] ^ hash;

  always_comb begin
    upd_cur = cnt_q[upd_idx];
    upd_nxt = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CNT_MAX) upd_nxt = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - 1'b1;
    end
  end

  // Write-first: a same-cycle update to the looked-up entry is visible.
  always_comb begin
    lk_cnt = cnt_q[lk_idx];
    if (upd_en && (upd_idx == lk_idx)) lk_cnt = upd_nxt;
  end

  generate
    if (GHR_W == 1) begin : g_ghr1
      assign ghr_d = upd_taken;
    end else begin : g_ghrn
      assign ghr_d = {ghr_q[GHR_W-2:0], upd_taken};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_RST;
      ghr_q <= '0;
      pv_q  <= 1'b0;
      pt_q  <= 1'b0;
      pi_q  <= '0;
    end else begin
      if (upd_en) begin
        cnt_q[upd_idx] <= upd_nxt;
        ghr_q          <= ghr_d;
      end
      pv_q <= req_en;
      if (req_en) begin
        pt_q <= lk_cnt[CNT_W-1];
        pi_q <= lk_idx;
      end
    end
  end

  assign pred_valid = pv_q;
  assign pred_taken = pt_q;
  assign pred_idx   = pi_q;
  assign ghr        = ghr_q;

endmodule
